coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor.sv | 114 +++++++++++
 tb/tb_coin_acceptor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes the two slot sensors, debounces the sampled code,
// and hands one classified code (or a reject) per insertion to the vending FSM.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sense5,
  input  logic       sense10,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic       reject,
  output logic       busy,
  output logic [7:0] cnt5,
  output logic [7:0] cnt10,
  output logic [7:0] rej_cnt,
  output logic [2:0] current_state
);

  localparam logic [2:0] IDLE     = 3'b000;
  localparam logic [2:0] DEBOUNCE = 3'b001;
  localparam logic [2:0] EMIT     = 3'b010;
  localparam logic [2:0] RELEASE  = 3'b011;

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_CYCLES);

  // Handshake: coin/reject are registered one-cycle strobes; the vending FSM
  // samples them whenever they are nonzero, there is no back-pressure.
  logic       s5_meta, s5, s10_meta, s10;
  logic [1:0] samp;
  logic [1:0] sample;
  logic [3:0] dcnt;
  logic [2:0] state;
  logic [1:0] fill;
  logic       hold;

  assign samp          = {s10, s5};
  assign busy          = (state != IDLE);
  assign current_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      s5_meta  <= 1'b0;
      s5       <= 1'b0;
      s10_meta <= 1'b0;
      s10      <= 1'b0;
      sample   <= 2'b00;
      dcnt     <= 4'd0;
      coin     <= 2'b00;
      reject   <= 1'b0;
      cnt5     <= 8'd0;
      cnt10    <= 8'd0;
      rej_cnt  <= 8'd0;
      state    <= RELEASE;
      fill     <= 2'd0;
      hold     <= 1'b1;
    end else begin
      s5_meta  <= sense5;
      s5       <= s5_meta;
      s10_meta <= sense10;
      s10      <= s10_meta;
      coin     <= 2'b00;
      reject   <= 1'b0;

      // The synchronizers restart empty after reset, so a coin left in the slot
      // is only trusted once the pipeline has refilled and read all-low.
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (hold && fill == 2'd2 && samp == 2'b00) hold <= 1'b0;

      case (state)
        IDLE: begin
          if (samp != 2'b00 && !hold) begin
            state  <= DEBOUNCE;
            sample <= samp;
            dcnt   <= 4'd1;
          end
        end
        DEBOUNCE: begin
          if (samp == 2'b00) begin
            state <= IDLE;
          end else if (samp != sample) begin
            sample <= samp;
            dcnt   <= 4'd1;
          end else if (dcnt < DEB_MAX) begin
            dcnt <= dcnt + 4'd1;
          end else if (accept_en || sample == 2'b11) begin
            state <= EMIT;
            coin  <= sample;
            if (sample == 2'b01) cnt5  <= cnt5 + 8'd1;
            if (sample == 2'b10) cnt10 <= cnt10 + 8'd1;
            if (sample == 2'b11) begin
              reject <= 1'b1;
              if (rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
            end
          end else begin
            state  <= RELEASE;
            reject <= 1'b1;
            if (rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
          end
        end
        EMIT: begin
          state <= RELEASE;
        end
        RELEASE: begin
          if (samp == 2'b00) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random insertions
// compared against a per-insertion outcome model derived from the timing rules.
module tb_coin_acceptor;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sense5, sense10, accept_en;
  logic [1:0] coin;
  logic       reject, busy;
  logic [7:0] cnt5, cnt10, rej_cnt;
  logic [2:0] current_state;

  int compared   = 0;
  int mismatched = 0;
  int m5 = 0, m10 = 0, mrej = 0;

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .sense5(sense5), .sense10(sense10),
    .accept_en(accept_en), .coin(coin), .reject(reject), .busy(busy),
    .cnt5(cnt5), .cnt10(cnt10), .rej_cnt(rej_cnt), .current_state(current_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt5"}, int'(cnt5), m5);
    check({tag, "_cnt10"}, int'(cnt10), m10);
    check({tag, "_rej_cnt"}, int'(rej_cnt), mrej);
  endtask

  // One insertion: sensor(s) high for len samples starting at edge k (t=0).
  // A code can only come out if the sample survives DEB+1 synchronized looks,
  // and then appears in the cycle after edge k+DEB+2.
  task automatic insert(input int typ, input int len, input bit acc, input string tag);
    int codes, seen, seen_t, rejs, rej_t;
    bit stable, emit, rej;
    codes = 0; seen = 0; seen_t = -1; rejs = 0; rej_t = -1;
    for (int t = 0; t < len + 10; t++) begin
      @(negedge clk);
      sense5    = (t < len) && typ[0];
      sense10   = (t < len) && typ[1];
      accept_en = (t == DEB + 2) ? acc : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (coin != 2'b00) begin codes++; seen = int'(coin); seen_t = t; end
      if (reject) begin rejs++; rej_t = t; end
    end
    stable = (len >= DEB + 1);
    emit   = stable && (acc || typ == 3);
    rej    = stable && (!acc || typ == 3);
    if (emit && typ == 1) m5 = (m5 + 1) % 256;
    if (emit && typ == 2) m10 = (m10 + 1) % 256;
    if (rej && mrej < 255) mrej++;
    check({tag, "_code_cycles"}, codes, emit ? 1 : 0);
    check({tag, "_code"}, seen, emit ? typ : 0);
    check({tag, "_code_time"}, seen_t, emit ? DEB + 2 : -1);
    check({tag, "_reject_pulses"}, rejs, rej ? 1 : 0);
    check({tag, "_reject_time"}, rej_t, rej ? DEB + 2 : -1);
    check_counters(tag);
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_state_end"}, int'(current_state), 0);
  endtask

  initial begin
    int codes, rejs;
    reset = 1'b1; sense5 = 1'b0; sense10 = 1'b0; accept_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_coin", int'(coin), 0);
    check("rst_reject", int'(reject), 0);
    check("rst_state", int'(current_state), 3);
    check("rst_busy", int'(busy), 1);
    check_counters("rst");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_state", int'(current_state), 0);
    check("post_rst_busy", int'(busy), 0);
    repeat (4) @(posedge clk);

    insert(1, 20, 1'b1, "rs5_accept");
    insert(2, 20, 1'b1, "rs10_first");
    insert(1, 20, 1'b1, "rs5_second");
    insert(1, 3, 1'b1, "glitch3");
    insert(3, 20, 1'b1, "both_invalid");
    insert(2, 20, 1'b0, "rs10_refused");
    insert(1, DEB, 1'b1, "len_short_edge");
    insert(1, DEB + 1, 1'b1, "len_min_edge");
    insert(3, 20, 1'b0, "invalid_refused");

    for (int i = 0; i < 40; i++)
      insert($urandom_range(1, 3), $urandom_range(1, 14), 1'($urandom_range(0, 1)), "random");

    // Reset while a coin is mid-debounce; it must stay ignored until removed.
    @(negedge clk); sense5 = 1'b1; accept_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_state_before_rst", int'(current_state), 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    m5 = 0; m10 = 0; mrej = 0;
    check("mid_rst_coin", int'(coin), 0);
    check("mid_rst_reject", int'(reject), 0);
    check("mid_rst_state", int'(current_state), 3);
    check("mid_rst_busy", int'(busy), 1);
    check_counters("mid_rst");
    @(negedge clk); reset = 1'b0;
    codes = 0; rejs = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (coin != 2'b00) codes++;
      if (reject) rejs++;
    end
    check("held_coin_codes", codes, 0);
    check("held_coin_rejects", rejs, 0);
    @(negedge clk); sense5 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("held_removed_state", int'(current_state), 0);
    insert(1, 20, 1'b1, "after_held");

    for (int i = 0; i < 260; i++) insert(1, DEB + 2, 1'b0, "rej_sat");
    check("rej_saturated", int'(rej_cnt), 255);
    for (int i = 0; i < 258; i++) insert(1, DEB + 2, 1'b1, "cnt5_wrap");
    check("cnt5_wrapped", int'(cnt5), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    mismatched++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "timeout");
  end

endmodule
